// File: rtl/frame_loader_pkg.sv
// Shared definitions for the LED-matrix frame loader: host command bytes and
// the parser state encoding (also used by the host-side test generator).
package frame_loader_pkg;

    localparam logic [7:0] CMD_FRAME = 8'h46;
    localparam logic [7:0] CMD_PIXEL = 8'h50;

    typedef enum logic [3:0] {
        S_IDLE,
        S_F_R,
        S_F_G,
        S_F_B,
        S_P_X,
        S_P_Y,
        S_P_R,
        S_P_G,
        S_P_B
    } state_t;

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte idle counter: flags a one-cycle expiry when TIMEOUT-1 idle cycles
// have accumulated while enabled and no clear is pending.
module byte_timeout #(
    parameter int TIMEOUT = 48000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            // Wrap on expiry so the counter never needs more than W bits.
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign expired = enable && !clear && (r_count == LAST);

endmodule

// File: rtl/frame_loader.sv
// Byte-stream command parser: turns FRAME and PIXEL commands from the UART
// into one-cycle pixel write strobes for the framebuffer.
module frame_loader
    import frame_loader_pkg::*;
#(
    parameter int X_RES   = 32,
    parameter int Y_RES   = 16,
    parameter int TIMEOUT = 48000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_strobe,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       strobe,
    output logic       frame_done,
    output logic       busy,
    output logic       error
);

    localparam logic [7:0] X_LAST = 8'(X_RES - 1);
    localparam logic [7:0] Y_LAST = 8'(Y_RES - 1);
    localparam logic [8:0] X_LIM  = 9'(X_RES);
    localparam logic [8:0] Y_LIM  = 9'(Y_RES);

    state_t     r_state;
    logic [7:0] r_fx, r_fy;
    logic [7:0] r_px, r_py, r_pr, r_pg;
    logic [7:0] r_x, r_y, r_r, r_g, r_b;
    logic       r_strobe, r_frame_done, r_busy, r_error;

    logic w_enable, w_clear, w_expired;

    assign w_enable = (r_state != S_IDLE);
    assign w_clear  = rx_strobe || !w_enable;

    byte_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (w_clear),
        .enable (w_enable),
        .expired(w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_fx         <= '0;
            r_fy         <= '0;
            r_px         <= '0;
            r_py         <= '0;
            r_pr         <= '0;
            r_pg         <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_r          <= '0;
            r_g          <= '0;
            r_b          <= '0;
            r_strobe     <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle and are overridden below;
            // non-blocking assignment means the last write in this block wins
            // while every read still sees the previous cycle's value.
            r_strobe     <= 1'b0;
            r_frame_done <= 1'b0;
            r_error      <= 1'b0;

            if (rx_strobe) begin
                case (r_state)
                    S_IDLE: begin
                        if (rx_data == CMD_FRAME) begin
                            r_state <= S_F_R;
                            r_fx    <= '0;
                            r_fy    <= '0;
                            r_busy  <= 1'b1;
                        end else if (rx_data == CMD_PIXEL) begin
                            r_state <= S_P_X;
                            r_busy  <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                    S_F_R: begin
                        r_pr    <= rx_data;
                        r_state <= S_F_G;
                    end
                    S_F_G: begin
                        r_pg    <= rx_data;
                        r_state <= S_F_B;
                    end
                    S_F_B: begin
                        r_x      <= r_fx;
                        r_y      <= r_fy;
                        r_r      <= r_pr;
                        r_g      <= r_pg;
                        r_b      <= rx_data;
                        r_strobe <= 1'b1;
                        if (r_fx == X_LAST && r_fy == Y_LAST) begin
                            r_frame_done <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_state <= S_F_R;
                            if (r_fx == X_LAST) begin
                                r_fx <= '0;
                                r_fy <= r_fy + 8'd1;
                            end else begin
                                r_fx <= r_fx + 8'd1;
                            end
                        end
                    end
                    S_P_X: begin
                        r_px    <= rx_data;
                        r_state <= S_P_Y;
                    end
                    S_P_Y: begin
                        r_py    <= rx_data;
                        r_state <= S_P_R;
                    end
                    S_P_R: begin
                        r_pr    <= rx_data;
                        r_state <= S_P_G;
                    end
                    S_P_G: begin
                        r_pg    <= rx_data;
                        r_state <= S_P_B;
                    end
                    S_P_B: begin
                        // Out-of-range coordinates are rejected whole, never clipped.
                        if (({1'b0, r_px} < X_LIM) && ({1'b0, r_py} < Y_LIM)) begin
                            r_x      <= r_px;
                            r_y      <= r_py;
                            r_r      <= r_pr;
                            r_g      <= r_pg;
                            r_b      <= rx_data;
                            r_strobe <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end else if (w_expired) begin
                r_error <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
            end
        end
    end

    assign x          = r_x;
    assign y          = r_y;
    assign r          = r_r;
    assign g          = r_g;
    assign b          = r_b;
    assign strobe     = r_strobe;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;
    assign error      = r_error;

endmodule

// File: tb/tb_frame_loader.sv
// Randomised scoreboard bench for frame_loader: a byte-level reference model
// predicts every write/error event; a negedge monitor compares them in order.
module tb_frame_loader;
    import frame_loader_pkg::*;

    localparam int XR = 4;
    localparam int YR = 2;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_strobe = 1'b0;
    logic [7:0] x, y, r, g, b;
    logic       strobe, frame_done, busy, error;

    frame_loader #(
        .X_RES  (XR),
        .Y_RES  (YR),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe),
        .x         (x),
        .y         (y),
        .r         (r),
        .g         (g),
        .b         (b),
        .strobe    (strobe),
        .frame_done(frame_done),
        .busy      (busy),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        bit         fd;
        bit         busy;
        logic [7:0] x, y, r, g, b;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;

    // Reference model: counts payload bytes per command and derives pixels
    // arithmetically from the byte index.
    int         m_mode = 0;   // 0 idle, 1 frame, 2 pixel
    int         m_cnt  = 0;
    int         m_gap  = 0;
    logic [7:0] m_buf[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void push_err();
        ev_t e;
        e.is_err = 1'b1; e.fd = 1'b0; e.busy = 1'b0;
        e.x = '0; e.y = '0; e.r = '0; e.g = '0; e.b = '0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_write(input int px, input int py, input logic [7:0] pr,
                                       input logic [7:0] pg, input logic [7:0] pb,
                                       input bit fd, input bit bz);
        ev_t e;
        e.is_err = 1'b0; e.fd = fd; e.busy = bz;
        e.x = 8'(px); e.y = 8'(py); e.r = pr; e.g = pg; e.b = pb;
        exp_q.push_back(e);
    endfunction

    function automatic void model_byte(input logic [7:0] d);
        int n;
        bit last;
        m_gap = 0;
        case (m_mode)
            0: begin
                if (d == CMD_FRAME) begin
                    m_mode = 1; m_cnt = 0;
                end else if (d == CMD_PIXEL) begin
                    m_mode = 2; m_cnt = 0;
                end else begin
                    push_err();
                end
            end
            1: begin
                m_buf[m_cnt % 3] = d;
                m_cnt++;
                if (m_cnt % 3 == 0) begin
                    n = m_cnt / 3 - 1;
                    last = (n == XR * YR - 1);
                    push_write(n % XR, n / XR, m_buf[0], m_buf[1], m_buf[2], last, !last);
                    if (last) m_mode = 0;
                end
            end
            default: begin
                m_buf[m_cnt] = d;
                m_cnt++;
                if (m_cnt == 5) begin
                    if (int'(m_buf[0]) < XR && int'(m_buf[1]) < YR)
                        push_write(m_buf[0], m_buf[1], m_buf[2], m_buf[3], m_buf[4], 1'b0, 1'b0);
                    else
                        push_err();
                    m_mode = 0;
                end
            end
        endcase
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            m_gap++;
            if (m_mode != 0 && m_gap == TO) begin
                push_err();
                m_mode = 0;
            end
            rx_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input int idle);
        idle_cycles(idle);
        model_byte(d);
        rx_data   = d;
        rx_strobe = 1'b1;
        @(posedge clk);
        #1;
        rx_strobe = 1'b0;
    endtask

    task automatic send_pixel(input logic [7:0] px, input logic [7:0] py, input logic [7:0] pr,
                              input logic [7:0] pg, input logic [7:0] pb, input int idle);
        send(CMD_PIXEL, 0);
        send(px, idle);
        send(py, idle);
        send(pr, idle);
        send(pg, idle);
        send(pb, idle);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x"}, x, 0);
        check({tag, "_y"}, y, 0);
        check({tag, "_r"}, r, 0);
        check({tag, "_g"}, g, 0);
        check({tag, "_b"}, b, 0);
        check({tag, "_strobe"}, strobe, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_error"}, error, 0);
    endtask

    // Monitor: every strobe or error pulse must match the next predicted event.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (reset_n && (strobe || error)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: actual strobe=%0b error=%0b x=%0d y=%0d required no event",
                         strobe, error, x, y);
            end else begin
                e = exp_q.pop_front();
                check("ev_error", error, e.is_err);
                check("ev_strobe", strobe, !e.is_err);
                check("ev_busy", busy, e.busy);
                check("ev_frame_done", frame_done, e.fd);
                if (!e.is_err) begin
                    check("ev_x", x, e.x);
                    check("ev_y", y, e.y);
                    check("ev_r", r, e.r);
                    check("ev_g", g, e.g);
                    check("ev_b", b, e.b);
                end
            end
        end else if (reset_n && frame_done) begin
            total++;
            bad++;
            $display("FAIL frame_done_without_strobe: actual frame_done=1 required 0");
        end
    end

    initial begin
        int gap;
        int kind;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed frame: byte i carries value i, random small gaps.
        send(CMD_FRAME, 0);
        check("busy_after_frame_cmd", busy, 1);
        for (int i = 0; i < XR * YR * 3; i++) send(8'(i), $urandom_range(0, 3));
        check("busy_after_frame", busy, 0);
        idle_cycles(2);

        send_pixel(8'd2, 8'd1, 8'hAA, 8'hBB, 8'hCC, 0);
        idle_cycles(2);
        send_pixel(8'd4, 8'd0, 8'd1, 8'd2, 8'd3, 0);
        check("busy_after_bad_pixel", busy, 0);
        send_pixel(8'd0, 8'd2, 8'd9, 8'd9, 8'd9, 1);
        send_pixel(8'd3, 8'd0, CMD_FRAME, CMD_PIXEL, 8'h11, 0);

        // Aborted frame: command plus two pixels, then silence.
        send(CMD_FRAME, 0);
        for (int i = 0; i < 6; i++) send(8'(8'h30 + i), 0);
        idle_cycles(20);
        check("busy_after_timeout", busy, 0);
        send_pixel(8'd1, 8'd1, 8'h5A, 8'hA5, 8'h3C, 0);

        send(8'h00, 0);
        send(8'hFF, 2);

        // Bytes landing exactly on expiry are accepted.
        send_pixel(8'd3, 8'd1, 8'h01, 8'h02, 8'h03, TO - 1);
        // One cycle later and the command is abandoned.
        send_pixel(8'd2, 8'd0, 8'h07, 8'h08, 8'h09, TO);
        idle_cycles(TO + 2);

        // Asynchronous reset in the middle of a frame.
        send(CMD_FRAME, 0);
        for (int i = 0; i < 5; i++) send(8'(8'hE0 + i), 0);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check("queue_at_reset", exp_q.size(), 0);
        exp_q.delete();
        m_mode = 0;
        m_gap  = 0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Fresh frame on 25 consecutive-cycle strobes with random payload.
        send(CMD_FRAME, 0);
        for (int i = 0; i < XR * YR * 3; i++) send(8'($urandom), 0);
        idle_cycles(2);

        // Random command soup, including occasional timeouts and stray bytes.
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                send(CMD_FRAME, $urandom_range(0, 2));
                for (int i = 0; i < XR * YR * 3; i++) begin
                    gap = ($urandom_range(0, 29) == 0) ? $urandom_range(TO - 1, TO + 1)
                                                       : $urandom_range(0, 2);
                    send(8'($urandom), gap);
                end
            end else if (kind == 3) begin
                send(8'($urandom), $urandom_range(0, 3));
            end else begin
                gap = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO) : $urandom_range(0, 1);
                send_pixel(8'($urandom_range(0, 5)), 8'($urandom_range(0, 3)),
                           8'($urandom), 8'($urandom), 8'($urandom), gap);
            end
        end

        idle_cycles(TO + 4);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
